// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the SR latch exerciser.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    CMD_SET   = 2'b00,
    CMD_RESET = 2'b01,
    CMD_AUTO  = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Expected readback pairs, packed as {q, qb}.
  localparam logic [1:0] PAIR_SET   = 2'b10;
  localparam logic [1:0] PAIR_RESET = 2'b01;

  // {q, qb} a healthy latch shows after the given operation.
  function automatic logic [1:0] expected_pair(input cmd_e op);
    return (op == CMD_SET) ? PAIR_SET : PAIR_RESET;
  endfunction

  // Opposite single operation, used to alternate in AUTO mode.
  function automatic cmd_e other_op(input cmd_e op);
    return (op == CMD_SET) ? CMD_RESET : CMD_SET;
  endfunction

endpackage

// File: rtl/sr_latch_exerciser_sync.sv
// Multi-stage bit synchronizer for asynchronous latch readback.
module sr_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/sr_latch_exerciser.sv
// Drives set/reset pulses into the analog SR latch and checks the readback.
module sr_latch_exerciser #(
  parameter int unsigned PULSE_W     = 4,
  parameter int unsigned SETTLE      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned N_AUTO      = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic             q_in,
  input  logic             qb_in,
  output logic             s_out,
  output logic             r_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             q_state
);

  import sr_latch_pkg::*;

  localparam int unsigned PH_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned N_OPS  = 2 * N_AUTO;
  localparam int unsigned OPS_W  = $clog2(N_OPS + 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  cmd_e             op_q, op_d;
  cmd_e             cmd_in;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [OPS_W-1:0] ops_left_q, ops_left_d;
  logic             s_d, r_d, busy_d, done_d, pass_d;
  logic [CNT_W-1:0] err_d;
  logic             q_sync, qb_sync;
  logic             mismatch;

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (q_sync)
  );

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_qb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (qb_in),
    .q     (qb_sync)
  );

  assign q_state = q_sync;

  // Next-state and next-output logic; drives only ever asserted on PULSE entry/hold.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ph_cnt_d   = ph_cnt_q;
    ops_left_d = ops_left_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    err_d      = err_cnt;
    cmd_in     = cmd_e'(cmd);
    mismatch   = ({q_sync, qb_sync} != expected_pair(op_q));

    case (state_q)
      ST_IDLE: begin
        if (start && (cmd_in != CMD_NOP)) begin
          state_d    = ST_PULSE;
          op_d       = (cmd_in == CMD_RESET) ? CMD_RESET : CMD_SET;
          ops_left_d = (cmd_in == CMD_AUTO) ? OPS_W'(N_OPS - 1) : '0;
          ph_cnt_d   = PH_W'(PULSE_W - 1);
          s_d        = (op_d == CMD_SET);
          r_d        = (op_d == CMD_RESET);
          busy_d     = 1'b1;
          err_d      = '0;
          pass_d     = 1'b0;
        end
      end
      ST_PULSE: begin
        if (ph_cnt_q == '0) begin
          state_d  = ST_SETTLE;
          ph_cnt_d = PH_W'(SETTLE - 1);
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
          s_d      = (op_q == CMD_SET);
          r_d      = (op_q == CMD_RESET);
        end
      end
      ST_SETTLE: begin
        if (ph_cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch && (err_cnt != ERR_MAX)) begin
          err_d = err_cnt + CNT_W'(1);
        end
        if (ops_left_q != '0) begin
          ops_left_d = ops_left_q - OPS_W'(1);
          op_d       = other_op(op_q);
          state_d    = ST_PULSE;
          ph_cnt_d   = PH_W'(PULSE_W - 1);
          s_d        = (op_d == CMD_SET);
          r_d        = (op_d == CMD_RESET);
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= CMD_SET;
      ph_cnt_q   <= '0;
      ops_left_q <= '0;
      s_out      <= 1'b0;
      r_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ph_cnt_q   <= ph_cnt_d;
      ops_left_q <= ops_left_d;
      s_out      <= s_d;
      r_out      <= r_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Randomized scoreboard bench for sr_latch_exerciser with a behavioural latch model.
module tb_sr_latch_exerciser;

  localparam int PW       = 4;
  localparam int ST       = 3;
  localparam int NA       = 3;
  localparam int LAT_ONE  = PW + ST + 2;
  localparam int LAT_AUTO = 2 * NA * (PW + ST + 1) + 1;

  // Latch model modes.
  localparam int M_OK  = 0;
  localparam int M_Q1  = 1;
  localparam int M_Q0  = 2;
  localparam int M_B1  = 3;
  localparam int M_B0  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] cmd;
  logic       q_in, qb_in;
  logic       s_out, r_out, busy, done, pass, q_state;
  logic [7:0] err_cnt;
  logic       s2, r2, busy2, done2, pass2, q_state2;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  sr_latch_exerciser #(
    .PULSE_W(PW), .SETTLE(ST), .SYNC_STAGES(2), .N_AUTO(NA), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .q_in(q_in), .qb_in(qb_in),
    .s_out(s_out), .r_out(r_out), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .q_state(q_state)
  );

  // Narrow-counter twin with a latch stuck at q=qb=1, to exercise saturation.
  sr_latch_exerciser #(
    .PULSE_W(PW), .SETTLE(ST), .SYNC_STAGES(2), .N_AUTO(NA), .CNT_W(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .q_in(1'b1), .qb_in(1'b1),
    .s_out(s2), .r_out(r2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .q_state(q_state2)
  );

  int mode = M_OK;
  bit q_lat = 1'b0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Healthy latch: follows s/r one cycle late.
  always @(posedge clk) begin
    if (s_out) q_lat <= 1'b1;
    else if (r_out) q_lat <= 1'b0;
  end

  function automatic logic [1:0] pins_now(input int m, input bit ql);
    case (m)
      M_OK:    return {ql, ~ql};
      M_Q1:    return 2'b10;
      M_Q0:    return 2'b01;
      M_B1:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  assign {q_in, qb_in} = pins_now(mode, q_lat);

  // {q,qb} the latch presents after an operation, by mode.
  function automatic logic [1:0] pair_after(input int m, input bit op_set);
    case (m)
      M_OK:    return op_set ? 2'b10 : 2'b01;
      M_Q1:    return 2'b10;
      M_Q0:    return 2'b01;
      M_B1:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  typedef struct {
    int exp_cyc;
    int err;
    bit pass_v;
    bit q_fin;
    int s_cyc;
    int r_cyc;
    bit first_s;
    int err2;
  } exp_t;

  exp_t sb_q[$];

  // Reference: walk the operation list and count readback mismatches.
  function automatic exp_t model(input logic [1:0] c, input int m, input int t0);
    exp_t e;
    int nops;
    bit is_set;
    logic [1:0] want;
    logic [1:0] got;
    nops      = (c == 2'b10) ? 2 * NA : 1;
    is_set    = (c != 2'b01);
    e.first_s = is_set;
    e.err     = 0;
    e.s_cyc   = 0;
    e.r_cyc   = 0;
    e.q_fin   = 1'b0;
    for (int i = 0; i < nops; i++) begin
      want = is_set ? 2'b10 : 2'b01;
      got  = pair_after(m, is_set);
      if (got != want) e.err++;
      if (is_set) e.s_cyc += PW; else e.r_cyc += PW;
      e.q_fin = got[1];
      is_set  = !is_set;
    end
    if (e.err > 255) e.err = 255;
    e.pass_v  = (e.err == 0);
    e.err2    = (nops < 3) ? nops : 3;
    e.exp_cyc = t0 + ((c == 2'b10) ? LAT_AUTO : LAT_ONE);
    return e;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int drive_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate per-run drive activity, compare against the scoreboard on done.
  int   s_acc, r_acc;
  bit   bad_drive, first_seen, first_s_act, twin_bad;
  exp_t e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_acc = 0; r_acc = 0; bad_drive = 0; first_seen = 0; first_s_act = 0; twin_bad = 0;
    end else begin
      if (s_out) s_acc++;
      if (r_out) r_acc++;
      if (s_out || r_out) drive_total++;
      if (s_out && r_out) bad_drive = 1;
      if ((s_out || r_out) && !busy) bad_drive = 1;
      if ((s_out || r_out) && !first_seen) begin
        first_seen  = 1;
        first_s_act = s_out;
      end
      if (s_out != s2 || r_out != r2 || busy != busy2 || done != done2) twin_bad = 1;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", sb_q.size(), 1);
        end else begin
          e_mon = sb_q.pop_front();
          chk("done_cycle", cyc, e_mon.exp_cyc);
          chk("pass", int'(pass), int'(e_mon.pass_v));
          chk("err_cnt", int'(err_cnt), e_mon.err);
          chk("q_state", int'(q_state), int'(e_mon.q_fin));
          chk("s_high_cycles", s_acc, e_mon.s_cyc);
          chk("r_high_cycles", r_acc, e_mon.r_cyc);
          chk("first_pulse_is_s", int'(first_s_act), int'(e_mon.first_s));
          chk("drive_overlap_or_stray", int'(bad_drive), 0);
          chk("busy_at_done", int'(busy), 0);
          chk("sat_err_cnt", int'(err_cnt2), e_mon.err2);
          chk("sat_pass", int'(pass2), int'(e_mon.err2 == 0));
          chk("sat_q_state", int'(q_state2), 1);
          chk("twin_lockstep", int'(twin_bad), 0);
        end
        s_acc = 0; r_acc = 0; bad_drive = 0; first_seen = 0; first_s_act = 0; twin_bad = 0;
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] c, input int m, input bit spur);
    int dc0, dt0, k;
    @(negedge clk);
    mode = m;
    repeat (3) @(negedge clk);
    cmd   = c;
    start = 1'b1;
    dc0   = done_cnt;
    dt0   = drive_total;
    if (c != 2'b11) sb_q.push_back(model(c, m, cyc));
    @(negedge clk);
    start = 1'b0;
    if (c == 2'b11) begin
      repeat (15) @(negedge clk);
      chk("nop_done_count", done_cnt, dc0);
      chk("nop_drive_cycles", drive_total, dt0);
      chk("nop_busy", int'(busy), 0);
    end else begin
      if (spur) begin
        k = $urandom_range(1, 6);
        repeat (k) @(negedge clk);
        if (busy) begin
          start = 1'b1;
          cmd   = 2'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
      end
      wait_drain();
    end
  endtask

  task automatic reset_mid_pulse();
    int dc0;
    @(negedge clk);
    mode = M_OK;
    repeat (3) @(negedge clk);
    cmd   = 2'b00;
    start = 1'b1;
    sb_q.push_back(model(2'b00, M_OK, cyc));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_s_out", int'(s_out), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_q_state", int'(q_state), 0);
    sb_q.delete();
    dc0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", done_cnt, dc0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cmd   = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_s_out", int'(s_out), 0);
    chk("reset_r_out", int'(r_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_q_state", int'(q_state), 0);
    rst_n = 1'b1;

    run_op(2'b00, M_OK, 1'b0);   // SET, healthy latch
    run_op(2'b01, M_Q1, 1'b0);   // RESET, latch stuck at q=1
    run_op(2'b10, M_OK, 1'b0);   // AUTO, healthy latch
    run_op(2'b10, M_B1, 1'b1);   // AUTO, q=qb=1, start pulsed while busy
    run_op(2'b11, M_OK, 1'b0);   // reserved command
    run_op(2'b00, M_OK, 1'b1);   // SET with a stray start mid-run
    reset_mid_pulse();
    run_op(2'b00, M_OK, 1'b0);   // SET after reset

    for (int t = 0; t < 24; t++) begin
      run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_exerciser.md
# sr_latch_exerciser

Digital driver and checker for the on-chip analog SR latch macro. It generates non-overlapping set and reset pulses of programmable width on the latch's `s` and `r` pins. After a settle window it reads `q`/`qb` back through synchronizers and reports pass/fail and an error count. It sits in the digital half of the user project: `ui_in` drives it, it drives the latch macro, and its results go out on `uo_out`.

## Interface
Parameters:
- `PULSE_W`, 4: cycles `s_out`/`r_out` are held high per operation (≥1).
- `SETTLE`, 3: idle cycles after a pulse before readback (must be ≥ `SYNC_STAGES`).
- `SYNC_STAGES`, 2: flip-flop depth of the `q`/`qb` synchronizers (≥2).
- `N_AUTO`, 3: number of SET/RESET pairs in AUTO mode (≥1).
- `CNT_W`, 8: width of the error counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `cmd`  in  2  operation: 00 SET, 01 RESET, 10 AUTO, 11 reserved (treated as no-op).
- `q_in`  in  1  latch `q`, asynchronous to `clk`.
- `qb_in`  in  1  latch `qb`, asynchronous to `clk`.
- `s_out`  out  1  drive to latch `s`.
- `r_out`  out  1  drive to latch `r`.
- `busy`  out  1  high from the first cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  last run had zero mismatches; valid from `done` until the next accepted `start`.
- `err_cnt`  out  CNT_W  mismatches in the current/last run, saturating.
- `q_state`  out  1  synchronized `q`, continuously.

## Operation
- FSM states: IDLE, PULSE, SETTLE, CHECK, DONE.
- IDLE + `start` + `cmd`∈{SET,RESET,AUTO}:
  - clear `err_cnt` and `pass`;
  - latch the op (AUTO begins with SET);
  - go to PULSE.
- IDLE + `start` + `cmd`=11: no effect; stays IDLE.
- PULSE: `s_out`=1 for SET or `r_out`=1 for RESET, held for PULSE_W cycles; then go to SETTLE.
- SETTLE: both drives low for SETTLE cycles; then go to CHECK.
- CHECK: one cycle. Compare synchronized pair to expected:
  - after SET, expect q=1, qb=0;
  - after RESET, expect q=0, qb=1.
  - Any other pair (including 11/00) is a mismatch: `err_cnt`+1, saturating at 2^CNT_W−1.
- After CHECK:
  - AUTO with operations remaining: toggle op, go to PULSE.
  - Otherwise go to DONE.
- DONE: one cycle; `done`=1, `pass`=(err_cnt==0); then go to IDLE.
- `s_out` and `r_out` are never high in the same cycle, and never high outside PULSE. AUTO gives a ≥SETTLE+1-cycle gap between opposite pulses.
- `start` while busy is ignored, with no queuing.
- All outputs are registered.

## Timing
- Reset values: `s_out`=0, `r_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, state IDLE. `q_state` and the synchronizer flops reset to 0.
- Reset asserted mid-operation: `s_out`/`r_out` drop asynchronously and the run is discarded, with no `done`.
- For `start` sampled at edge k, with k+1 denoting the cycle immediately after edge k:
  - `busy` and the drive go high in cycle k+1;
  - the drive is high in cycles k+1 … k+PULSE_W;
  - SETTLE occupies the next SETTLE cycles;
  - CHECK is at cycle k+PULSE_W+SETTLE+1;
  - `done` is at k+PULSE_W+SETTLE+2, with `busy` low in the same cycle.
- Single-op latency from `start` to `done`: PULSE_W+SETTLE+2 cycles.
- AUTO latency: 2·N_AUTO·(PULSE_W+SETTLE+1)+1 cycles.
- `err_cnt` updates in the cycle after CHECK.
- `q_state` lags a `q_in` change by SYNC_STAGES cycles.

## Structure
- Package `sr_latch_pkg`: `cmd_e` (SET, RESET, AUTO, NOP) and `state_e` enums, plus the expected-pair constants.
- Sub-module `sr_sync`: a SYNC_STAGES-deep bit synchronizer with async active-low reset. Instantiate it twice, for `q_in` and `qb_in`.
- One shared down-counter serves both the PULSE and SETTLE phases. A separate op counter tracks AUTO progress.

## Test plan
(PULSE_W=4, SETTLE=3, SYNC_STAGES=2, N_AUTO=3, CNT_W=8; latch model with 1-cycle delay)
- SET with a correct latch model → `s_out` high exactly 4 cycles; `done` 9 cycles after `start`; `pass`=1; `err_cnt`=0; `q_state`=1.
- RESET with the latch model stuck at q=1 → `r_out` high 4 cycles; `done`; `pass`=0; `err_cnt`=1.
- AUTO with a correct model → 6 alternating pulses starting with `s`; `s`/`r` never overlap; `done` at cycle 49; `pass`=1.
- AUTO with the model forcing q=qb=1 → `err_cnt`=6, `pass`=0. A pre-loaded counter at 255 followed by a mismatch leaves it at 255.
- `start` pulsed during busy, and `cmd`=11 in IDLE → ignored; no extra pulses; `done` count unchanged.
- `rst_n` low during PULSE → `s_out`=0 in the same cycle (async); no `done`; all outputs at reset values; the next SET runs normally.
